reg_bank_file: RTL and testbench
================================

Name: reg_bank_file

Overview:
- Banked register file directly downstream of the write-back mux; consumes its per-bank word outputs (reg_inputs) plus per-bank write enables.
- One single-write / single-read register array per bank, with a per-register valid bit used as a scoreboard.
- Supplies operands to the crossbar/ALU trees with one-cycle registered read latency and same-cycle write bypass.
- Flags read-before-write (stall) and write-over-live-data (sticky error) hazards.

Parameters:
- N_BANKS, 64, number of banks; equals write-back lane count.
- REG_DEPTH, 32, registers per bank; power of two, ≥2.
- WORD_W, 32, data word width (word_t).
- ADDR_W, $clog2(REG_DEPTH), per-bank register address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  N_BANKS  per-bank write enable (reg_we).
- wr_addr  in  N_BANKS*ADDR_W  per-bank write address.
- wr_data  in  N_BANKS*WORD_W  per-bank write data from write-back stage.
- rd_en  in  N_BANKS  per-bank read request.
- rd_addr  in  N_BANKS*ADDR_W  per-bank read address.
- rd_inv  in  N_BANKS  clear valid bit of the read register (last use).
- clear_all  in  1  synchronous clear of all valid bits (new DAG block).
- rd_data  out  N_BANKS*WORD_W  registered read data.
- rd_vld  out  N_BANKS  rd_data lane holds a valid operand.
- stall  out  1  OR of lanes that read an invalid register last cycle.
- waw_err  out  1  sticky: a write hit a register still valid and not being invalidated.

Behaviour:
- Reset (rst_n=0, async): all valid bits 0; rd_data=0, rd_vld=0, stall=0, waw_err=0. Register contents need not be reset. A reset mid-operation discards in-flight reads. No write or read is honoured in the cycle rst_n deasserts.
- Write: on posedge with wr_en[b]=1, mem[b][wr_addr[b]] <= wr_data[b] and valid[b][wr_addr[b]] <= 1. Lanes are independent; no cross-bank conflicts.
- Read latency is 1 cycle. If rd_en[b]=1 at edge N, rd_data[b] and rd_vld[b] are updated at edge N+1:
  - If rd_en[b], wr_en[b] and rd_addr==wr_addr, this is a bypass: rd_data=wr_data[b], rd_vld=1.
  - Otherwise rd_data=mem value and rd_vld=valid bit.
  - If rd_en[b]=0, rd_data holds its previous value and rd_vld=0.
- stall is registered: 1 at N+1 if any lane had rd_en=1 and resolved to rd_vld=0. stall is advisory only; the block does not retry reads.
- Invalidate: rd_inv[b] counts only with rd_en[b]. At the edge it clears valid[b][rd_addr]. If a write to the same address occurs in the same cycle, the write wins and valid stays 1.
- waw_err is set when, at an edge, wr_en[b]=1 and valid[b][wr_addr] is already 1, unless a same-cycle rd_inv on that address clears it. Cleared only by reset.
- clear_all at an edge clears every valid bit. Same-cycle writes still occur and set their valid bits (write has priority). Same-cycle reads still return the pre-clear state.
- Address out of range is impossible by construction (power-of-two depth).
- Implementation uses one flop array per bank plus a valid vector per bank; no inter-bank muxing.

Test Plan:
- Reset then read bank 0 addr 3 → next cycle rd_vld[0]=0, stall=1, rd_data=0.
- Write bank 5 addr 2 = 0xDEADBEEF; read it the following cycle → next edge rd_data[5]=0xDEADBEEF, rd_vld[5]=1, stall=0.
- Same-cycle write and read on bank 7 addr 9, data 0x12345678 → next edge rd_data[7]=0x12345678, rd_vld=1 (bypass).
- Read bank 1 addr 4 with rd_inv=1 after a write; read again → second read gives rd_vld=0, stall=1. Repeat with a same-cycle write to addr 4 → valid persists.
- Write bank 2 addr 0 twice without invalidate → waw_err=1 after the second edge and stays 1 until rst_n low. Write, then read+inv, then rewrite → waw_err stays 0.
- Fill all banks, assert clear_all with a simultaneous write to bank 3 addr 1 → all reads rd_vld=0 except bank 3 addr 1. Assert rst_n low mid-stream → outputs zero immediately, with no clock needed.

Source files
------------

// File: rtl/reg_bank_file.sv
// Banked register file: one single-write/single-read array per bank with a
// per-register valid scoreboard, 1-cycle registered reads and write bypass.
module reg_bank_file #(
  parameter int N_BANKS   = 64,
  parameter int REG_DEPTH = 32,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = $clog2(REG_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_BANKS-1:0]          wr_en,
  input  logic [N_BANKS*ADDR_W-1:0]   wr_addr,
  input  logic [N_BANKS*WORD_W-1:0]   wr_data,
  input  logic [N_BANKS-1:0]          rd_en,
  input  logic [N_BANKS*ADDR_W-1:0]   rd_addr,
  input  logic [N_BANKS-1:0]          rd_inv,
  input  logic                        clear_all,
  output logic [N_BANKS*WORD_W-1:0]   rd_data,
  output logic [N_BANKS-1:0]          rd_vld,
  output logic                        stall,
  output logic                        waw_err
);

  logic                 active_r;
  logic                 stall_r;
  logic                 waw_err_r;
  logic [N_BANKS-1:0]   wr_go_s;
  logic [N_BANKS-1:0]   rd_go_s;
  logic [N_BANKS-1:0]   lane_vld_s;
  logic [N_BANKS-1:0]   lane_miss_s;
  logic [N_BANKS-1:0]   lane_waw_s;

  // Suppresses all reads and writes on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
    end else begin
      active_r <= 1'b1;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [WORD_W-1:0]    mem_r [REG_DEPTH];
    logic [REG_DEPTH-1:0] valid_r;
    logic [REG_DEPTH-1:0] valid_nxt_s;
    logic [ADDR_W-1:0]    wa_s;
    logic [ADDR_W-1:0]    ra_s;
    logic [WORD_W-1:0]    wd_s;
    logic [WORD_W-1:0]    rdata_nxt_s;
    logic [WORD_W-1:0]    rd_data_r;
    logic                 rd_vld_r;
    logic                 bypass_s;
    logic                 inv_s;

    assign wa_s     = wr_addr[b*ADDR_W +: ADDR_W];
    assign ra_s     = rd_addr[b*ADDR_W +: ADDR_W];
    assign wd_s     = wr_data[b*WORD_W +: WORD_W];
    assign wr_go_s[b] = active_r & wr_en[b];
    assign rd_go_s[b] = active_r & rd_en[b];
    assign bypass_s = rd_go_s[b] & wr_go_s[b] & (ra_s == wa_s);
    assign inv_s    = rd_go_s[b] & rd_inv[b];

    assign lane_vld_s[b]  = bypass_s | valid_r[ra_s];
    assign lane_miss_s[b] = rd_go_s[b] & ~lane_vld_s[b];
    // A same-address last-use invalidate retires the old value, so no hazard
    assign lane_waw_s[b]  = wr_go_s[b] & valid_r[wa_s] & ~(inv_s & (ra_s == wa_s));

    // Scoreboard next state: write beats clear_all beats invalidate
    always_comb begin
      valid_nxt_s = valid_r;
      for (int i = 0; i < REG_DEPTH; i++) begin
        if (wr_go_s[b] && (wa_s == ADDR_W'(i))) begin
          valid_nxt_s[i] = 1'b1;
        end else if (clear_all) begin
          valid_nxt_s[i] = 1'b0;
        end else if (inv_s && (ra_s == ADDR_W'(i))) begin
          valid_nxt_s[i] = 1'b0;
        end else begin
          valid_nxt_s[i] = valid_r[i];
        end
      end
    end

    // Read data source selection with same-cycle write bypass
    always_comb begin
      if (bypass_s) begin
        rdata_nxt_s = wd_s;
      end else begin
        rdata_nxt_s = mem_r[ra_s];
      end
    end

    // Storage array; contents are deliberately not reset
    always_ff @(posedge clk) begin
      if (wr_go_s[b]) begin
        mem_r[wa_s] <= wd_s;
      end
    end

    // Valid-bit scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= {REG_DEPTH{1'b0}};
      end else begin
        valid_r <= valid_nxt_s;
      end
    end

    // Registered read port; data holds when idle, valid drops
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_r <= {WORD_W{1'b0}};
        rd_vld_r  <= 1'b0;
      end else if (rd_go_s[b]) begin
        rd_data_r <= rdata_nxt_s;
        rd_vld_r  <= lane_vld_s[b];
      end else begin
        rd_data_r <= rd_data_r;
        rd_vld_r  <= 1'b0;
      end
    end

    assign rd_data[b*WORD_W +: WORD_W] = rd_data_r;
    assign rd_vld[b]                   = rd_vld_r;
  end

  // Stall flag and sticky write-over-live-data error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r   <= 1'b0;
      waw_err_r <= 1'b0;
    end else begin
      stall_r   <= |lane_miss_s;
      waw_err_r <= waw_err_r | (|lane_waw_s);
    end
  end

  assign stall   = stall_r;
  assign waw_err = waw_err_r;

endmodule

// File: tb/tb_reg_bank_file.sv
// Directed self-checking bench for reg_bank_file.
module tb_reg_bank_file;
  localparam int NB = 64;
  localparam int AW = 5;
  localparam int WW = 32;

  logic              clk;
  logic              rst_n;
  logic [NB-1:0]     wr_en;
  logic [NB*AW-1:0]  wr_addr;
  logic [NB*WW-1:0]  wr_data;
  logic [NB-1:0]     rd_en;
  logic [NB*AW-1:0]  rd_addr;
  logic [NB-1:0]     rd_inv;
  logic              clear_all;
  logic [NB*WW-1:0]  rd_data;
  logic [NB-1:0]     rd_vld;
  logic              stall;
  logic              waw_err;

  int n_cmp = 0;
  int n_err = 0;

  reg_bank_file #(.N_BANKS(NB), .REG_DEPTH(32), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_inv(rd_inv),
    .clear_all(clear_all), .rd_data(rd_data), .rd_vld(rd_vld),
    .stall(stall), .waw_err(waw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lane(input int b);
    return {32'd0, rd_data[b*WW +: WW]};
  endfunction

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; rd_inv = '0; clear_all = 1'b0;
  endtask

  task automatic set_wr(input int b, input logic [AW-1:0] a, input logic [WW-1:0] d);
    wr_en[b] = 1'b1; wr_addr[b*AW +: AW] = a; wr_data[b*WW +: WW] = d;
  endtask

  task automatic set_rd(input int b, input logic [AW-1:0] a, input logic inv);
    rd_en[b] = 1'b1; rd_addr[b*AW +: AW] = a; rd_inv[b] = inv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_vld", {63'd0, |rd_vld}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_waw", {63'd0, waw_err}, 64'd0);
    check("rst_data", {63'd0, |rd_data}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Write issued in the reset-release cycle must be ignored
    rst_n = 1'b1;
    set_wr(6, 5'd6, 32'h0000AAAA);
    step();
    idle();
    set_rd(0, 5'd3, 1'b0);
    set_rd(6, 5'd6, 1'b0);
    step();
    check("empty_vld", rd_vld, 64'd0);
    check("empty_stall", {63'd0, stall}, 64'd1);
    check("empty_data0", lane(0), 64'd0);

    // Plain write then read
    idle();
    set_wr(5, 5'd2, 32'hDEADBEEF);
    step();
    idle();
    set_rd(5, 5'd2, 1'b0);
    step();
    check("rd5_data", lane(5), 64'hDEADBEEF);
    check("rd5_vld", rd_vld, 64'h20);
    check("rd5_stall", {63'd0, stall}, 64'd0);
    idle();
    step();
    check("hold_data", lane(5), 64'hDEADBEEF);
    check("hold_vld", rd_vld, 64'd0);

    // Same-cycle bypass
    set_wr(7, 5'd9, 32'h12345678);
    set_rd(7, 5'd9, 1'b0);
    step();
    check("byp_data", lane(7), 64'h12345678);
    check("byp_vld", rd_vld, 64'h80);
    check("byp_stall", {63'd0, stall}, 64'd0);

    // Last-use invalidate
    idle();
    set_wr(1, 5'd4, 32'h00000011);
    step();
    idle();
    set_rd(1, 5'd4, 1'b1);
    step();
    check("inv_first_data", lane(1), 64'h11);
    check("inv_first_vld", rd_vld, 64'h2);
    idle();
    set_rd(1, 5'd4, 1'b0);
    step();
    check("inv_second_vld", rd_vld, 64'd0);
    check("inv_second_stall", {63'd0, stall}, 64'd1);
    idle();
    set_wr(1, 5'd4, 32'h00000022);
    step();
    idle();
    set_rd(1, 5'd4, 1'b1);
    set_wr(1, 5'd4, 32'h00000033);
    step();
    check("invwr_data", lane(1), 64'h33);
    check("invwr_vld", rd_vld, 64'h2);
    idle();
    set_rd(1, 5'd4, 1'b0);
    step();
    check("invwr_keep_vld", rd_vld, 64'h2);
    check("invwr_keep_data", lane(1), 64'h33);
    check("invwr_stall", {63'd0, stall}, 64'd0);
    check("invwr_waw", {63'd0, waw_err}, 64'd0);

    // Write, read+invalidate, rewrite: no hazard
    idle();
    set_wr(2, 5'd1, 32'h00000A01);
    step();
    idle();
    set_rd(2, 5'd1, 1'b1);
    step();
    idle();
    set_wr(2, 5'd1, 32'h00000A02);
    step();
    check("waw_clean", {63'd0, waw_err}, 64'd0);

    // Double write without invalidate: sticky hazard
    idle();
    set_wr(2, 5'd0, 32'h00000B01);
    step();
    check("waw_first", {63'd0, waw_err}, 64'd0);
    idle();
    set_wr(2, 5'd0, 32'h00000B02);
    step();
    check("waw_set", {63'd0, waw_err}, 64'd1);
    idle();
    repeat (3) step();
    check("waw_sticky", {63'd0, waw_err}, 64'd1);

    // Fill all banks, then clear_all with a priority write and pre-clear reads
    idle();
    for (int b = 0; b < NB; b++) set_wr(b, 5'd1, 32'(b));
    step();
    idle();
    clear_all = 1'b1;
    set_wr(3, 5'd1, 32'h0000C3C3);
    for (int b = 0; b < NB; b++) set_rd(b, 5'd1, 1'b0);
    step();
    check("clr_pre_vld", rd_vld, {NB{1'b1}});
    check("clr_pre_data3", lane(3), 64'hC3C3);
    check("clr_pre_data10", lane(10), 64'd10);
    idle();
    for (int b = 0; b < NB; b++) set_rd(b, 5'd1, 1'b0);
    step();
    check("clr_post_vld", rd_vld, 64'h8);
    check("clr_post_data3", lane(3), 64'hC3C3);
    check("clr_post_stall", {63'd0, stall}, 64'd1);

    // Asynchronous reset mid-stream, no clock edge needed
    idle();
    set_rd(3, 5'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", rd_vld, 64'd0);
    check("arst_data", {63'd0, |rd_data}, 64'd0);
    check("arst_stall", {63'd0, stall}, 64'd0);
    check("arst_waw", {63'd0, waw_err}, 64'd0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    set_rd(3, 5'd1, 1'b0);
    step();
    check("arst_valid_gone", rd_vld, 64'd0);
    check("arst_valid_stall", {63'd0, stall}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
